// File: rtl/timer_pkg.sv
// timer_pkg
//   Shared definitions for the countdown timer: FSM state encoding,
//   time-field limits and a wrap-around increment helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  // Increment a time field, wrapping from max_v back to zero.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max_v);
    return (v == max_v) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge
//   Two-flop synchronizer plus rising-edge detector for one raw button.
//   Produces a one-cycle registered pulse per press, so a press rising
//   before edge N yields o_pulse high between edges N+2 and N+3.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   i_btn   - raw button level, asynchronous to clk
//   o_pulse - single-cycle pulse per rising edge of i_btn
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_v1;
  logic r_v2;
  logic r_armed;
  logic r_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta <= i_btn;
      r_sync <= r_meta;
      r_prev <= r_sync;
      // r_v2 marks that r_sync holds a real sampled level, not its reset value.
      r_v1   <= 1'b1;
      r_v2   <= r_v1;
      // Only arm once the button has been seen low after reset, so a button
      // held through reset release cannot fire until it falls and rises again.
      if (r_v2 && !r_sync) begin
        r_armed <= 1'b1;
      end
      r_pulse <= r_sync & ~r_prev & r_armed;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/timer_controller.sv
// timer_controller
//   Kitchen-style countdown timer. Buttons set minutes/seconds in IDLE,
//   start/pause toggles countdown, clear cancels. Reaching 00:00 raises
//   the alarm for ALARM_SECS seconds (or until any button), then IDLE.
// Parameters:
//   TICK_DIV   - clk cycles per countdown second
//   ALARM_SECS - seconds the alarm stays asserted
// Ports:
//   clk, reset                                   - clock, async active-high reset
//   btn_start, btn_min, btn_sec, btn_clear       - raw button levels
//   min_out, sec_out                             - current time, 0..59 each
//   running                                      - high in RUN only
//   alarm                                        - high in ALARM only
module timer_controller
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  output logic [5:0] min_out,
  output logic [5:0] sec_out,
  output logic       running,
  output logic       alarm
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ACNT_MAX  = AW'(ALARM_SECS - 1);

  logic w_p_start;
  logic w_p_min;
  logic w_p_sec;
  logic w_p_clear;
  logic w_any;
  logic w_tick;
  logic w_time_zero;
  logic [PW-1:0] w_presc_next;

  state_t        r_state;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic          r_running;
  logic          r_alarm;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_acnt;

  btn_edge u_start (.clk(clk), .reset(reset), .i_btn(btn_start), .o_pulse(w_p_start));
  btn_edge u_min   (.clk(clk), .reset(reset), .i_btn(btn_min),   .o_pulse(w_p_min));
  btn_edge u_sec   (.clk(clk), .reset(reset), .i_btn(btn_sec),   .o_pulse(w_p_sec));
  btn_edge u_clear (.clk(clk), .reset(reset), .i_btn(btn_clear), .o_pulse(w_p_clear));

  assign w_any        = w_p_start | w_p_min | w_p_sec | w_p_clear;
  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_time_zero  = (r_min == 6'd0) && (r_sec == 6'd0);
  assign w_presc_next = w_tick ? '0 : r_presc + 1'b1;

  // Button actions take priority over a coincident prescaler tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
      r_presc   <= '0;
      r_acnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_p_clear) begin
            r_min <= 6'd0;
            r_sec <= 6'd0;
          end else if (w_p_start) begin
            if (!w_time_zero) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_presc   <= '0;
            end
          end else begin
            if (w_p_min) r_min <= inc_wrap(r_min, MAX_MIN);
            if (w_p_sec) r_sec <= inc_wrap(r_sec, MAX_SEC);
          end
        end

        ST_RUN: begin
          if (w_p_clear) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_min     <= 6'd0;
            r_sec     <= 6'd0;
            r_presc   <= '0;
          end else if (w_p_start) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end else begin
            r_presc <= w_presc_next;
            if (w_tick) begin
              if (r_sec != 6'd0) begin
                r_sec <= r_sec - 6'd1;
                // Last second elapsed: the alarm period starts on this edge,
                // and its prescaler restarts from zero via w_presc_next.
                if ((r_min == 6'd0) && (r_sec == 6'd1)) begin
                  r_state   <= ST_ALARM;
                  r_running <= 1'b0;
                  r_alarm   <= 1'b1;
                  r_acnt    <= '0;
                end
              end else if (r_min != 6'd0) begin
                r_sec <= MAX_SEC;
                r_min <= r_min - 6'd1;
              end
            end
          end
        end

        ST_PAUSE: begin
          if (w_p_clear) begin
            r_state <= ST_IDLE;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_presc <= '0;
          end else if (w_p_start) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_presc   <= '0;
          end
        end

        ST_ALARM: begin
          if (w_any) begin
            r_state <= ST_IDLE;
            r_alarm <= 1'b0;
            r_presc <= '0;
            r_acnt  <= '0;
          end else begin
            r_presc <= w_presc_next;
            if (w_tick) begin
              if (r_acnt == ACNT_MAX) begin
                r_state <= ST_IDLE;
                r_alarm <= 1'b0;
                r_acnt  <= '0;
              end else begin
                r_acnt <= r_acnt + 1'b1;
              end
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign min_out = r_min;
  assign sec_out = r_sec;
  assign running = r_running;
  assign alarm   = r_alarm;

endmodule
